bcd_countdown_timer: RTL and testbench



---
 rtl/timer_pkg.sv | 19 +
 rtl/bcd_digit_down.sv | 23 ++
 rtl/bcd_countdown_timer.sv | 99 +++++++++
 tb/tb_bcd_countdown_timer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM encoding, digit radix
// limits and the input clamp applied to serially loaded digits.
package timer_pkg;

   localparam int DIGIT_W      = 4;
   localparam int BCD_MAX      = 9;
   localparam int SEC_TENS_MAX = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_RUN  = 2'd2
   } timer_state_e;

   function automatic logic [DIGIT_W-1:0] clamp_bcd(input logic [DIGIT_W-1:0] d);
      return (d > DIGIT_W'(BCD_MAX)) ? DIGIT_W'(BCD_MAX) : d;
   endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the decrement chain: wraps 0 -> MAX and borrows onward
// when a borrow arrives at zero.
module bcd_digit_down
   import timer_pkg::*;
#(
   parameter int MAX = BCD_MAX
) (
   input  logic [DIGIT_W-1:0] value,
   input  logic               borrow_in,
   output logic [DIGIT_W-1:0] next_value,
   output logic               borrow_out
);

   always_comb begin
      next_value = value;
      if (borrow_in) begin
         next_value = (value == '0) ? DIGIT_W'(MAX) : value - DIGIT_W'(1);
      end
   end

   assign borrow_out = borrow_in && (value == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with serial digit load, prescaled decrement,
// optional mm:ss radix on digit 1, and a one-cycle done pulse.
module bcd_countdown_timer
   import timer_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 100,
   parameter int MMSS     = 1
) (
   input  logic                      clock,
   input  logic                      clearn,
   input  logic [DIGIT_W-1:0]        data,
   input  logic                      loadn,
   input  logic                      en,
   output logic [DIGIT_W*DIGITS-1:0] digits,
   output logic                      zero,
   output logic                      running,
   output logic                      done
);

   localparam int VAL_W = DIGIT_W * DIGITS;
   localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   timer_state_e     state_q, state_d;
   logic [VAL_W-1:0] digits_q, digits_d;
   logic [VAL_W-1:0] dec_value;
   logic [VAL_W-1:0] shifted;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic             done_q, done_d;
   logic [DIGITS:0]  borrow;
   logic             load, advance, wrap, dec;

   assign load    = ~loadn;
   assign zero    = (digits_q == '0);
   // A zero value never advances the prescaler, so counting cannot underflow.
   assign advance = en && !zero && !load;
   assign wrap    = (pre_q == PRE_LAST);
   assign dec     = advance && wrap;
   assign shifted = {digits_q[VAL_W-DIGIT_W-1:0], clamp_bcd(data)};

   assign borrow[0] = dec;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      localparam int DMAX = (g == 1 && MMSS != 0) ? SEC_TENS_MAX : BCD_MAX;
      bcd_digit_down #(.MAX(DMAX)) u_digit (
         .value      (digits_q[g*DIGIT_W +: DIGIT_W]),
         .borrow_in  (borrow[g]),
         .next_value (dec_value[g*DIGIT_W +: DIGIT_W]),
         .borrow_out (borrow[g+1])
      );
   end

   always_comb begin
      digits_d = digits_q;
      pre_d    = pre_q;
      done_d   = 1'b0;
      state_d  = state_q;
      if (load) begin
         digits_d = shifted;
         pre_d    = '0;
      end else if (advance) begin
         if (wrap) begin
            pre_d    = '0;
            digits_d = dec_value;
            done_d   = (dec_value == '0) && !borrow[DIGITS];
         end else begin
            pre_d = pre_q + PRE_W'(1);
         end
      end
      // State mirrors the value just produced and the enable sampled this edge.
      if (digits_d == '0) begin
         state_d = ST_IDLE;
      end else if (en) begin
         state_d = ST_RUN;
      end else begin
         state_d = ST_HOLD;
      end
   end

   always_ff @(posedge clock) begin
      if (!clearn) begin
         state_q  <= ST_IDLE;
         digits_q <= '0;
         pre_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         digits_q <= digits_d;
         pre_q    <= pre_d;
         done_q   <= done_d;
      end
   end

   assign digits  = digits_q;
   assign running = (state_q == ST_RUN);
   assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: an mm:ss instance and a pure-decimal
// instance share stimulus; expectations are hand-computed constants.
module tb_bcd_countdown_timer;

   logic        clock = 1'b0;
   logic        clearn;
   logic [3:0]  data;
   logic        loadn;
   logic        en;
   logic [15:0] digits, digits_b;
   logic        zero, zero_b;
   logic        running, running_b;
   logic        done, done_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   bcd_countdown_timer #(.DIGITS(4), .TICK_DIV(4), .MMSS(1)) dut (
      .clock   (clock),
      .clearn  (clearn),
      .data    (data),
      .loadn   (loadn),
      .en      (en),
      .digits  (digits),
      .zero    (zero),
      .running (running),
      .done    (done)
   );

   bcd_countdown_timer #(.DIGITS(4), .TICK_DIV(4), .MMSS(0)) dut_dec (
      .clock   (clock),
      .clearn  (clearn),
      .data    (data),
      .loadn   (loadn),
      .en      (en),
      .digits  (digits_b),
      .zero    (zero_b),
      .running (running_b),
      .done    (done_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic load_digit(input logic [3:0] d);
      loadn = 1'b0;
      data  = d;
      step(1);
      loadn = 1'b1;
   endtask

   task automatic do_reset();
      clearn = 1'b0;
      step(1);
      clearn = 1'b1;
   endtask

   initial begin
      clearn = 1'b0;
      loadn  = 1'b1;
      en     = 1'b0;
      data   = 4'd0;
      step(1);
      chk("rst_digits", digits, 16'h0000);
      chk("rst_zero", zero, 1);
      chk("rst_running", running, 0);
      chk("rst_done", done, 0);
      chk("rst_zero_dec", zero_b, 1);
      clearn = 1'b1;

      // serial load with clamp
      loadn = 1'b0;
      data = 4'd8; step(1);
      data = 4'd5; step(1);
      data = 4'd7; step(1);
      chk("load_0857", digits, 16'h0857);
      chk("load_zero_flag", zero, 0);
      data = 4'hC; step(1);
      chk("load_clamp", digits, 16'h8579);
      loadn = 1'b1;
      do_reset();
      chk("rst_from_nonzero", digits, 16'h0000);
      chk("rst_from_nonzero_z", zero, 1);

      // countdown with borrow through both radices
      load_digit(4'd8); load_digit(4'd0); load_digit(4'd0);
      chk("pre_cd_mmss", digits, 16'h0800);
      chk("pre_cd_dec", digits_b, 16'h0800);
      chk("hold_not_running", running, 0);
      en = 1'b1;
      step(3);
      chk("cd_before_tick", digits, 16'h0800);
      chk("cd_running", running, 1);
      step(1);
      chk("cd_mmss_borrow", digits, 16'h0759);
      chk("cd_dec_borrow", digits_b, 16'h0799);
      en = 1'b0;
      do_reset();

      // done pulse
      load_digit(4'd2);
      en = 1'b1;
      step(3);
      chk("done_pre", digits, 16'h0002);
      step(1);
      chk("done_first_dec", digits, 16'h0001);
      chk("done_not_yet", done, 0);
      step(3);
      chk("done_pre_last", done, 0);
      step(1);
      chk("done_digits", digits, 16'h0000);
      chk("done_pulse", done, 1);
      chk("done_zero", zero, 1);
      chk("done_running", running, 0);
      chk("done_dec_inst", done_b, 1);
      step(1);
      chk("done_one_cycle", done, 0);
      step(5);
      chk("done_stay_zero", digits, 16'h0000);
      chk("done_no_repeat", done, 0);
      en = 1'b0;

      // pause keeps partial prescaler count
      load_digit(4'd1); load_digit(4'd0);
      chk("pause_loaded", digits, 16'h0010);
      en = 1'b1; step(2);
      en = 1'b0; step(10);
      chk("pause_hold", digits, 16'h0010);
      chk("pause_not_running", running, 0);
      en = 1'b1; step(1);
      chk("pause_resume1", digits, 16'h0010);
      step(1);
      chk("pause_resume2", digits, 16'h0009);

      // load on the wrap edge wins and restarts the prescaler
      step(3);
      chk("prio_pre_wrap", digits, 16'h0009);
      load_digit(4'd4);
      chk("prio_load_wins", digits, 16'h0094);
      chk("prio_running", running, 1);
      step(3);
      chk("prio_restart_hold", digits, 16'h0094);
      step(1);
      chk("prio_restart_dec", digits, 16'h0093);

      // reset one edge before reaching zero
      en = 1'b0;
      do_reset();
      load_digit(4'd1);
      en = 1'b1;
      step(3);
      chk("midrst_pre", digits, 16'h0001);
      clearn = 1'b0;
      step(1);
      chk("midrst_digits", digits, 16'h0000);
      chk("midrst_done", done, 0);
      chk("midrst_running", running, 0);
      clearn = 1'b1;
      step(4);
      chk("midrst_no_late_done", done, 0);

      // load to zero gives no done
      en = 1'b0;
      load_digit(4'd5);
      chk("lz_loaded", digits, 16'h0005);
      load_digit(4'd0); load_digit(4'd0); load_digit(4'd0);
      chk("lz_shifted", digits, 16'h5000);
      load_digit(4'd0);
      chk("lz_zero", digits, 16'h0000);
      chk("lz_no_done", done, 0);
      chk("lz_zero_flag", zero, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
